// File: rtl/uart_rx_frame_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_fsm
//
// UART receive front end. The serial line is brought into the clock domain
// through a two-flop synchroniser. Each bit is sampled three times around
// its centre and resolved by majority vote. A frame is walked as start bit,
// WIDTH data bits LSB-first, an optional parity bit and a stop bit. The data
// word and the received parity bit go to an external combinational parity
// checker. Its error result is folded into single-cycle status pulses for
// the register block.
//
// Ports
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx_in      : asynchronous serial line, idle high
//   prescale   : clocks per bit (even, >= 8), stable while busy is low
//   par_en     : frame carries a parity bit
//   par_type   : parity sense; consumed by the external checker only
//   par_err    : parity checker result (combinational)
//   rx_data    : assembled data word
//   par_bit    : received parity bit
//   par_chk_en : parity check enable, high in STOP when parity is enabled
//   data_valid : one-cycle pulse, good frame received
//   par_error  : one-cycle pulse, parity mismatch
//   stop_error : one-cycle pulse, stop bit sampled low
//   busy       : high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_frame_fsm #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_type,
   input  logic               par_err,
   output logic [WIDTH-1:0]   rx_data,
   output logic               par_bit,
   output logic               par_chk_en,
   output logic               data_valid,
   output logic               par_error,
   output logic               stop_error,
   output logic               busy
);

   localparam int                 BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WIDTH - 1);
   localparam logic [PRESC_W-1:0] ONE_P    = PRESC_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t             state_q;
   logic               syncMeta_q;
   logic               rxSync_q;
   logic               s0_q;
   logic               s1_q;
   logic [PRESC_W-1:0] edgeCnt_q;
   logic [PRESC_W-1:0] edgeCnt_d;
   logic [BIT_W-1:0]   bitCnt_q;
   logic [WIDTH-1:0]   rxData_q;
   logic               parBit_q;
   logic               dataValid_q;
   logic               parError_q;
   logic               stopError_q;

   logic [PRESC_W-1:0] halfPresc;
   logic               atSample0;
   logic               atSample1;
   logic               atVote;
   logic               atLastEdge;
   logic               vote;
   logic               leaveToIdle;
   logic               unusedParType;

   // par_type is wired straight to the parity checker; this block only
   // consumes the checker's verdict.
   assign unusedParType = par_type;

   // Three samples at edges M-1, M and M+1 of each bit, with M half the bit
   // period; the third sample is the live synchronised line at vote time.
   assign halfPresc   = prescale >> 1;
   assign atSample0   = (edgeCnt_q == halfPresc - ONE_P);
   assign atSample1   = (edgeCnt_q == halfPresc);
   assign atVote      = (edgeCnt_q == halfPresc + ONE_P);
   assign atLastEdge  = (edgeCnt_q == prescale - ONE_P);
   assign vote        = (s0_q & s1_q) | (s0_q & rxSync_q) | (s1_q & rxSync_q);
   assign leaveToIdle = atVote & (((state_q == START) & vote) | (state_q == STOP));

   // Edge counter next value. The cycle in which IDLE first sees the line
   // low already counts as edge 0 of the start bit, so the count resumes
   // at 1. Leaving for IDLE early (glitch, or the stop-bit vote) rewinds it.
   always_comb begin
      edgeCnt_d = edgeCnt_q + ONE_P;
      if (state_q == IDLE) begin
         edgeCnt_d = rxSync_q ? '0 : ONE_P;
      end else if (atLastEdge || leaveToIdle) begin
         edgeCnt_d = '0;
      end
   end

   // Frame state machine with synchroniser, sample capture and registered
   // status. The stop bit is only walked as far as its vote so that a
   // following start bit is caught on its first low cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         syncMeta_q  <= 1'b1;
         rxSync_q    <= 1'b1;
         s0_q        <= 1'b0;
         s1_q        <= 1'b0;
         edgeCnt_q   <= '0;
         bitCnt_q    <= '0;
         rxData_q    <= '0;
         parBit_q    <= 1'b0;
         dataValid_q <= 1'b0;
         parError_q  <= 1'b0;
         stopError_q <= 1'b0;
      end else begin
         syncMeta_q  <= rx_in;
         rxSync_q    <= syncMeta_q;
         edgeCnt_q   <= edgeCnt_d;
         dataValid_q <= 1'b0;
         parError_q  <= 1'b0;
         stopError_q <= 1'b0;
         if (atSample0) begin
            s0_q <= rxSync_q;
         end
         if (atSample1) begin
            s1_q <= rxSync_q;
         end
         case (state_q)
            IDLE: begin
               if (!rxSync_q) begin
                  state_q <= START;
               end
            end
            START: begin
               if (atVote && vote) begin
                  state_q <= IDLE;
               end else if (atLastEdge) begin
                  state_q  <= DATA;
                  bitCnt_q <= '0;
               end
            end
            DATA: begin
               if (atVote) begin
                  rxData_q[bitCnt_q] <= vote;
               end
               if (atLastEdge) begin
                  if (bitCnt_q == LAST_BIT) begin
                     state_q <= par_en ? PARITY : STOP;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (atVote) begin
                  parBit_q <= vote;
               end
               if (atLastEdge) begin
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (atVote) begin
                  stopError_q <= ~vote;
                  parError_q  <= par_en & par_err;
                  dataValid_q <= vote & ~(par_en & par_err);
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rx_data    = rxData_q;
   assign par_bit    = parBit_q;
   assign data_valid = dataValid_q;
   assign par_error  = parError_q;
   assign stop_error = stopError_q;
   assign busy       = (state_q != IDLE);
   assign par_chk_en = par_en & (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_fsm
//
// Drives serial frames into uart_rx_frame_fsm and compares every status
// pulse against a frame-level model: the pulse cycle follows from the bit
// count and the bit period, and the pulse kind follows from the stop bit
// and the parity rule. A small behavioural parity checker sits on the
// checker-side ports.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_fsm;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 6;

   logic               clk = 1'b0;
   logic               rst;
   logic               rx_in;
   logic [PRESC_W-1:0] prescale;
   logic               par_en;
   logic               par_type;
   logic               par_err;
   logic [WIDTH-1:0]   rx_data;
   logic               par_bit;
   logic               par_chk_en;
   logic               data_valid;
   logic               par_error;
   logic               stop_error;
   logic               busy;

   typedef struct {
      int         cyc;
      bit         dv;
      bit         pe;
      bit         se;
      logic [7:0] data;
      logic       pbit;
   } pulse_t;

   pulse_t seenQ[$];
   pulse_t expQ[$];
   pulse_t monRec;
   int     cyc = 0;
   int     chkSeen = 0;
   int     chkExp = 0;
   int     checks = 0;
   int     errors = 0;
   logic   lastPbit = 1'b0;

   uart_rx_frame_fsm #(
      .WIDTH  (WIDTH),
      .PRESC_W(PRESC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .prescale  (prescale),
      .par_en    (par_en),
      .par_type  (par_type),
      .par_err   (par_err),
      .rx_data   (rx_data),
      .par_bit   (par_bit),
      .par_chk_en(par_chk_en),
      .data_valid(data_valid),
      .par_error (par_error),
      .stop_error(stop_error),
      .busy      (busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Downstream parity checker: even parity wants data^parity == 0,
   // odd parity wants it to be 1.
   assign par_err = par_chk_en & ((^rx_data) ^ par_bit ^ par_type);

   // Cycle counter; during cycle k of a frame it reads startCyc+k
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse and check-enable monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid || par_error || stop_error) begin
            monRec.cyc  = cyc;
            monRec.dv   = data_valid;
            monRec.pe   = par_error;
            monRec.se   = stop_error;
            monRec.data = rx_data;
            monRec.pbit = par_bit;
            seenQ.push_back(monRec);
         end
         if (par_chk_en) chkSeen++;
      end
   end

   // Hold the line idle for n cycles
   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send one frame and queue the outcome the model predicts for it
   task automatic send_frame(input logic [7:0] data, input bit pb, input bit stopb, input bit spike);
      int     P = int'(prescale);
      int     M = P / 2;
      int     startCyc;
      int     n;
      bit     bits[$];
      bit     perr;
      pulse_t e;
      bits.push_back(1'b0);
      for (int i = 0; i < WIDTH; i++) bits.push_back(data[i]);
      if (par_en) bits.push_back(pb);
      bits.push_back(stopb);
      n = bits.size() - 1;
      startCyc = cyc;
      for (int k = 0; k < bits.size(); k++) begin
         for (int c = 0; c < P; c++) begin
            rx_in = (spike && k >= 1 && k <= WIDTH && c == M) ? ~bits[k] : bits[k];
            @(posedge clk);
            #1;
         end
      end
      perr = par_en && (((^data) ^ pb ^ par_type) != 1'b0);
      if (par_en) lastPbit = pb;
      e.cyc  = startCyc + n * P + M + 4;
      e.dv   = stopb && !perr;
      e.pe   = perr;
      e.se   = !stopb;
      e.data = data;
      e.pbit = lastPbit;
      expQ.push_back(e);
      if (par_en) chkExp += M + 2;
   endtask

   // Compare everything the monitor saw against the model, then clear
   task automatic check_pulses(input string name);
      int n;
      checks++;
      if (seenQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL %s pulse count: got %0d, want %0d", name, seenQ.size(), expQ.size());
      end
      n = (seenQ.size() < expQ.size()) ? seenQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (seenQ[i].cyc !== expQ[i].cyc || seenQ[i].dv !== expQ[i].dv ||
             seenQ[i].pe !== expQ[i].pe || seenQ[i].se !== expQ[i].se ||
             seenQ[i].data !== expQ[i].data || seenQ[i].pbit !== expQ[i].pbit) begin
            errors++;
            $display("[TB] FAIL %s pulse %0d: got cyc=%0d dv=%0b pe=%0b se=%0b data=%02h pbit=%0b, want cyc=%0d dv=%0b pe=%0b se=%0b data=%02h pbit=%0b",
                     name, i, seenQ[i].cyc, seenQ[i].dv, seenQ[i].pe, seenQ[i].se, seenQ[i].data, seenQ[i].pbit,
                     expQ[i].cyc, expQ[i].dv, expQ[i].pe, expQ[i].se, expQ[i].data, expQ[i].pbit);
         end
      end
      checks++;
      if (chkSeen != chkExp) begin
         errors++;
         $display("[TB] FAIL %s par_chk_en cycles: got %0d, want %0d", name, chkSeen, chkExp);
      end
      seenQ.delete();
      expQ.delete();
      chkSeen = 0;
      chkExp  = 0;
   endtask

   // Reset values
   task automatic test_reset();
      rst      = 1'b1;
      rx_in    = 1'b1;
      prescale = 6'd8;
      par_en   = 1'b0;
      par_type = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      lastPbit = 1'b0;
      checks++;
      if ({busy, par_chk_en, data_valid, par_error, stop_error, par_bit, rx_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset outputs: got busy=%0b chk=%0b dv=%0b pe=%0b se=%0b pbit=%0b data=%02h, want all 0",
                  busy, par_chk_en, data_valid, par_error, stop_error, par_bit, rx_data);
      end
      idle(4);
   endtask

   // Plain 8N1 frame at prescale 8
   task automatic test_basic();
      prescale = 6'd8;
      par_en   = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      idle(16);
      check_pulses("basic_A5");
   endtask

   // Parity good and bad at prescale 8, plus odd parity
   task automatic test_parity();
      prescale = 6'd8;
      par_en   = 1'b1;
      par_type = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      idle(16);
      check_pulses("parity_even_ok");
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      idle(16);
      check_pulses("parity_even_bad");
      par_type = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
      idle(16);
      check_pulses("parity_odd_ok");
      par_type = 1'b0;
      par_en   = 1'b0;
   endtask

   // Stop bit low, then recovery with a clean frame
   task automatic test_stop_error();
      prescale = 6'd8;
      par_en   = 1'b0;
      send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      idle(24);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      idle(16);
      check_pulses("stop_error");
   endtask

   // Three low cycles must be rejected at the start-bit vote
   task automatic test_glitch(input int P);
      int M = P / 2;
      bit expBusy;
      prescale = PRESC_W'(P);
      for (int c = 0; c < M + 7; c++) begin
         rx_in = (c < 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         expBusy = (c >= 3) && (c <= M + 3);
         checks++;
         if (busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL glitch busy P=%0d cycle %0d: got %0b, want %0b", P, c, busy, expBusy);
         end
         @(posedge clk);
         #1;
      end
      idle(2 * P);
      check_pulses("glitch");
   endtask

   // One-cycle spikes at the middle sample of every data bit
   task automatic test_spikes();
      prescale = 6'd8;
      for (int i = 0; i < 3; i++) begin
         par_en   = 1'($urandom);
         par_type = 1'($urandom);
         send_frame(8'($urandom), 1'($urandom), 1'b1, 1'b1);
         idle(16);
      end
      check_pulses("spikes");
      par_en = 1'b0;
   endtask

   // Reset during data bit 4, then a clean 0xFF frame
   task automatic test_reset_midframe();
      logic [7:0] d = 8'hC3;
      bit         b;
      prescale = 6'd8;
      par_en   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         b = (k == 0) ? 1'b0 : d[k-1];
         for (int c = 0; c < ((k == 5) ? 3 : 8); c++) begin
            rx_in = b;
            @(posedge clk);
            #1;
         end
      end
      rst   = 1'b1;
      rx_in = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lastPbit = 1'b0;
      checks++;
      if ({busy, par_chk_en, data_valid, par_error, stop_error, par_bit, rx_data} !== '0) begin
         errors++;
         $display("[TB] FAIL midframe reset: got busy=%0b chk=%0b dv=%0b pe=%0b se=%0b pbit=%0b data=%02h, want all 0",
                  busy, par_chk_en, data_valid, par_error, stop_error, par_bit, rx_data);
      end
      idle(16);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
      idle(16);
      check_pulses("reset_midframe");
   endtask

   // Random frames with random bit period, parity mode and error injection
   task automatic test_random();
      int P;
      logic [7:0] d;
      bit pb;
      for (int i = 0; i < 10; i++) begin
         P        = 2 * int'($urandom_range(4, 16));
         prescale = PRESC_W'(P);
         par_en   = 1'($urandom);
         par_type = 1'($urandom);
         d        = 8'($urandom);
         pb       = (^d) ^ par_type;
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         send_frame(d, pb, ($urandom_range(0, 5) != 0), 1'b0);
         idle(2 * P);
         check_pulses("random");
      end
      par_en = 1'b0;
   endtask

   // Frames with no idle gap between stop bit and next start bit
   task automatic test_back_to_back();
      int P = 2 * int'($urandom_range(4, 12));
      logic [7:0] d;
      prescale = PRESC_W'(P);
      par_en   = 1'($urandom);
      par_type = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom);
         send_frame(d, (^d) ^ par_type, 1'b1, 1'b0);
      end
      idle(2 * P);
      check_pulses("back_to_back");
      par_en = 1'b0;
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop_error();
      test_glitch(8);
      test_glitch(2 * int'($urandom_range(5, 16)));
      test_spikes();
      test_reset_midframe();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_fsm.md
Name: uart_rx_frame_fsm

Overview:
UART receive front end. It synchronises the serial line, oversamples each bit with a 3-sample majority vote, and walks the frame (start, data LSB-first, optional parity, stop). It presents the assembled data word and the received parity bit, plus an enable, to the downstream combinational parity checker. It consumes the checker's error result and reports frame status to the UART register block as single-cycle pulses.

Parameters:
WIDTH, 8, data bits per frame
PRESC_W, 6, width of prescale input and edge counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_in  in  1  asynchronous serial line, idle high
prescale  in  PRESC_W  oversampling ratio; even, >=8; change only while busy=0
par_en  in  1  1 = frame carries a parity bit
par_type  in  1  0 even, 1 odd; passed through to the checker
par_err  in  1  error result from the parity checker (combinational)
rx_data  out  WIDTH  assembled data word, to checker and register block
par_bit  out  1  received parity bit, to checker
par_chk_en  out  1  parity-check enable, to checker
data_valid  out  1  1-cycle pulse: good frame received
par_error  out  1  1-cycle pulse: parity mismatch
stop_error  out  1  1-cycle pulse: stop bit sampled low
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. Synchroniser flops = 1. Counters = 0. rx_data = 0, par_bit = 0, all pulses = 0, busy = 0. rst mid-frame aborts the frame with no pulse.
- rx_in passes through a 2-flop synchroniser to give rx_s. All timing below is relative to rx_s, which adds 2 cycles of latency.
- edge_cnt counts 0..prescale-1, then wraps to 0 at a bit boundary. bit_cnt counts 0..WIDTH-1.
- Sample points, with M = prescale>>1 and V = M+1:
  - s0 is captured at edge M-1, s1 at edge M.
  - At edge V, vote = majority(s0, s1, rx_s).
- IDLE: rx_s==0 -> START. That cycle is edge 0, so edge_cnt<=1.
- START:
  - At V, vote==1 -> glitch: return to IDLE, no pulse.
  - Otherwise, at edge prescale-1 -> DATA, bit_cnt<=0.
- DATA:
  - At V, rx_data[bit_cnt]<=vote.
  - At edge prescale-1: if bit_cnt==WIDTH-1, go to PARITY when par_en=1, else STOP. Otherwise bit_cnt++.
- PARITY: at V, par_bit<=vote. At edge prescale-1 -> STOP.
- STOP:
  - par_chk_en = par_en throughout STOP, combinationally from state.
  - At V, all of the following register together and state<=IDLE (the remainder of the stop bit is not waited for, allowing back-to-back frames):
    - stop_error <= ~vote
    - par_error <= par_en & par_err
    - data_valid <= vote & ~(par_en & par_err)
  - The three pulses clear the next cycle. data_valid and the error pulses are mutually exclusive.
- rx_data and par_bit hold their value until overwritten by the next frame's votes.
- A start bit while busy is impossible by construction. A low line in IDLE right after a stop error begins a new frame immediately.
- par_en is sampled continuously and must be stable while busy.

Test Plan:
1. prescale=8, par_en=0, send 0xA5 with rx_in falling at cycle 0 -> data_valid=1 exactly at cycle 80 for one cycle; rx_data=0xA5; par_error=stop_error=0.
2. prescale=8, par_en=1, par_type=0, send 0x3C with parity 0; downstream checker connected -> par_chk_en high during STOP; data_valid pulses at cycle 88; rx_data=0x3C.
3. Same as 2 but parity bit sent as 1 -> par_error pulses at cycle 88; data_valid stays 0; rx_data=0x3C.
4. prescale=8, stop bit driven 0 -> stop_error pulse; data_valid 0. Then the line returns high and a frame carrying 0x5A is sent -> received correctly.
5. Glitch test: rx_in low for 3 cycles, then high -> FSM returns to IDLE (busy drops at the start-bit vote); no pulses.
6. Single-cycle spikes and rst mid-frame:
   - A 1-cycle spike on each data bit at edge M -> vote rejects it and data is intact.
   - Assert rst at bit 4 -> busy=0 next cycle, all outputs 0; the following 0xFF frame is received cleanly.
